// File: rtl/reg_file_sb_if.sv
// Register-file bus between the pipeline (master) and reg_file_sb (slave).
// Every field is sampled each cycle and qualified by its own enable; there is no valid/ready stall.
interface reg_file_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] A1;
  logic [ADDR_WIDTH-1:0] A2;
  logic [DATA_WIDTH-1:0] RD1;
  logic [DATA_WIDTH-1:0] RD2;
  logic                  Busy1;
  logic                  Busy2;
  logic                  IssueD;
  logic                  RegWriteD;
  logic [ADDR_WIDTH-1:0] RdD;
  logic                  KillE;
  logic [ADDR_WIDTH-1:0] KillRd;
  logic                  RegWriteW;
  logic [ADDR_WIDTH-1:0] RdW;
  logic [DATA_WIDTH-1:0] ResultW;
  logic [DATA_WIDTH-1:0] a0;

  modport master (
    output A1, A2, IssueD, RegWriteD, RdD, KillE, KillRd, RegWriteW, RdW, ResultW,
    input  RD1, RD2, Busy1, Busy2, a0
  );

  modport slave (
    input  A1, A2, IssueD, RegWriteD, RdD, KillE, KillRd, RegWriteW, RdW, ResultW,
    output RD1, RD2, Busy1, Busy2, a0
  );
endinterface

// File: rtl/reg_file_sb.sv
// 32x32 integer register file with W->D bypass on both read ports and a
// per-register pending-write scoreboard that drives the Busy flags.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 2
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);
  localparam int NREG   = 2 ** ADDR_WIDTH;
  localparam int SW     = CNT_WIDTH + 2;
  localparam int A0_IDX = 10;
  localparam logic [SW-1:0] CNT_MAX = SW'((2 ** CNT_WIDTH) - 1);

  logic [DATA_WIDTH-1:0] regs     [NREG];
  logic [CNT_WIDTH-1:0]  cnt      [NREG];
  logic [CNT_WIDTH-1:0]  cnt_next [NREG];
  logic [SW-1:0]         up       [NREG];
  logic [SW-1:0]         dn       [NREG];
  logic                  wb1;
  logic                  wb2;

  // Sum is formed in a wider field so that inc and up to two decrements net
  // out before the clamp; x0 is never tracked.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      up[r] = {2'b00, cnt[r]}
            + SW'(bus.IssueD && bus.RegWriteD && (bus.RdD == ADDR_WIDTH'(r)));
      dn[r] = SW'(bus.RegWriteW && (bus.RdW == ADDR_WIDTH'(r)))
            + SW'(bus.KillE && (bus.KillRd == ADDR_WIDTH'(r)));
      if (r == 0) begin
        cnt_next[r] = '0;
      end else if (up[r] < dn[r]) begin
        cnt_next[r] = '0;
      end else if ((up[r] - dn[r]) > CNT_MAX) begin
        cnt_next[r] = CNT_MAX[CNT_WIDTH-1:0];
      end else begin
        cnt_next[r] = CNT_WIDTH'(up[r] - dn[r]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (bus.RegWriteW && (bus.RdW != '0)) begin
        regs[bus.RdW] <= bus.ResultW;
      end
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_next[r];
      end
    end
  end

  // More completions than outstanding writers, or a fourth writer in flight,
  // means the pipeline lost track of a destination.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 1; r < NREG; r++) begin
        assert (up[r] >= dn[r]);
        assert (up[r] <= (dn[r] + CNT_MAX));
      end
    end
  end

  assign wb1 = bus.RegWriteW && (bus.RdW == bus.A1);
  assign wb2 = bus.RegWriteW && (bus.RdW == bus.A2);

  assign bus.RD1 = (bus.A1 == '0) ? '0 : (wb1 ? bus.ResultW : regs[bus.A1]);
  assign bus.RD2 = (bus.A2 == '0) ? '0 : (wb2 ? bus.ResultW : regs[bus.A2]);

  // A writer retiring this cycle is served by the bypass, so it is discounted.
  assign bus.Busy1 = (bus.A1 != '0) && ((cnt[bus.A1] - CNT_WIDTH'(wb1)) != '0);
  assign bus.Busy2 = (bus.A2 != '0) && ((cnt[bus.A2] - CNT_WIDTH'(wb2)) != '0);

  assign bus.a0 = regs[A0_IDX];
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized bench for reg_file_sb against an array/integer
// model of register contents and pending-writer counts.
module tb_reg_file_sb;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst;

  reg_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] m_regs [NREG];
  int            m_cnt  [NREG];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (bus.RegWriteW && bus.RdW == a) return bus.ResultW;
    return m_regs[a];
  endfunction

  function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a);
    int pend;
    if (a == '0) return '0;
    pend = m_cnt[a] - ((bus.RegWriteW && bus.RdW == a) ? 1 : 0);
    return (pend != 0) ? 32'd1 : 32'd0;
  endfunction

  function automatic int net_count(input int r);
    int v;
    v = m_cnt[r];
    if (bus.IssueD && bus.RegWriteD && bus.RdD == AW'(r)) v++;
    if (bus.RegWriteW && bus.RdW == AW'(r)) v--;
    if (bus.KillE && bus.KillRd == AW'(r)) v--;
    return v;
  endfunction

  function automatic bit legal();
    for (int r = 1; r < NREG; r++) begin
      if (net_count(r) < 0 || net_count(r) > CMAX) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rd1"},   bus.RD1,        exp_rd(bus.A1));
    chk({tag, ".rd2"},   bus.RD2,        exp_rd(bus.A2));
    chk({tag, ".busy1"}, 32'(bus.Busy1), exp_busy(bus.A1));
    chk({tag, ".busy2"}, 32'(bus.Busy2), exp_busy(bus.A2));
    chk({tag, ".a0"},    bus.a0,         m_regs[10]);
  endtask

  task automatic model_update();
    int v;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] = '0;
        m_cnt[r]  = 0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        v = net_count(r);
        m_cnt[r] = (v < 0) ? 0 : ((v > CMAX) ? CMAX : v);
      end
      if (bus.RegWriteW && bus.RdW != '0) m_regs[bus.RdW] = bus.ResultW;
    end
  endtask

  // Inputs are set after a falling edge; outputs checked, then the model
  // follows the rising edge with the same inputs.
  task automatic step(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst           = 1'b0;
    bus.A1        = '0;
    bus.A2        = '0;
    bus.IssueD    = 1'b0;
    bus.RegWriteD = 1'b0;
    bus.RdD       = '0;
    bus.KillE     = 1'b0;
    bus.KillRd    = '0;
    bus.RegWriteW = 1'b0;
    bus.RdW       = '0;
    bus.ResultW   = '0;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    bus.IssueD    = 1'b1;
    bus.RegWriteD = 1'b1;
    bus.RdD       = rd;
  endtask

  task automatic wb(input logic [AW-1:0] rd, input logic [DW-1:0] val);
    bus.RegWriteW = 1'b1;
    bus.RdW       = rd;
    bus.ResultW   = val;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);

    // Reset state
    idle(); bus.A1 = 5'd5; bus.A2 = 5'd31;
    #1;
    chk("reset.rd1", bus.RD1, 32'h0);
    chk("reset.rd2", bus.RD2, 32'h0);
    chk("reset.busy", 32'({bus.Busy1, bus.Busy2}), 32'h0);
    chk("reset.a0", bus.a0, 32'h0);
    step("reset");

    // Write to x0 is dropped
    idle(); wb(5'd0, 32'hDEADBEEF); step("x0_wr");
    idle();
    #1; chk("x0_read", bus.RD1, 32'h0);
    step("x0_rd");

    // Same-cycle bypass, then the stored value
    idle(); issue(5'd7); bus.A1 = 5'd7; step("iss7");
    idle(); wb(5'd7, 32'h1234); bus.A1 = 5'd7;
    #1; chk("bypass.rd1", bus.RD1, 32'h1234);
    chk("bypass.busy1", 32'(bus.Busy1), 32'h0);
    step("wb7");
    idle(); bus.A1 = 5'd7;
    #1; chk("stored.rd1", bus.RD1, 32'h1234);
    step("rd7");

    // Busy window for a single in-flight writer
    idle(); issue(5'd3); bus.A1 = 5'd3; step("iss3");
    for (int c = 1; c <= 3; c++) begin
      idle(); bus.A1 = 5'd3;
      #1; chk("busy3.inflight", 32'(bus.Busy1), 32'h1);
      step("wait3");
    end
    idle(); wb(5'd3, 32'h33); bus.A1 = 5'd3;
    #1; chk("busy3.wbcycle", 32'(bus.Busy1), 32'h0);
    step("wb3");
    idle(); bus.A1 = 5'd3;
    #1; chk("busy3.after", 32'(bus.Busy1), 32'h0);
    chk("rd3.after", bus.RD1, 32'h33);
    step("rd3");

    // Two writers, one flushed, one retired
    idle(); issue(5'd4); bus.A2 = 5'd4; step("iss4a");
    idle(); issue(5'd4); bus.A2 = 5'd4; step("iss4b");
    idle(); bus.KillE = 1'b1; bus.KillRd = 5'd4; bus.A2 = 5'd4;
    #1; chk("kill4.samecycle", 32'(bus.Busy2), 32'h1);
    step("kill4");
    idle(); wb(5'd4, 32'h44); bus.A2 = 5'd4;
    #1; chk("cnt4.one_left", 32'(bus.Busy2), 32'h0);
    step("wb4");
    idle(); bus.A2 = 5'd4;
    #1; chk("cnt4.zero", 32'(bus.Busy2), 32'h0);
    step("rd4");

    // a0 export and reset in the middle of pending writes
    idle(); issue(5'd10); step("iss10");
    idle(); wb(5'd10, 32'd42); step("wb10");
    idle();
    #1; chk("a0.written", bus.a0, 32'd42);
    step("a0");
    idle(); issue(5'd9); step("iss9a");
    idle(); issue(5'd9); bus.A1 = 5'd9; step("iss9b");
    idle(); bus.A1 = 5'd9;
    #1; chk("cnt9.pending", 32'(bus.Busy1), 32'h1);
    rst = 1'b1; issue(5'd9); wb(5'd12, 32'h77);
    step("rst_mid");
    idle(); bus.A1 = 5'd9; bus.A2 = 5'd10;
    #1; chk("rst_mid.a0", bus.a0, 32'h0);
    chk("rst_mid.busy1", 32'(bus.Busy1), 32'h0);
    chk("rst_mid.rd2", bus.RD2, 32'h0);
    step("post_rst");

    // Randomized traffic, kept within the legal pending-writer range
    for (int n = 0; n < 600; n++) begin
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 16 && !ok; t++) begin
        idle();
        bus.A1        = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
        bus.A2        = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
        bus.IssueD    = ($urandom_range(0, 1) == 1);
        bus.RegWriteD = ($urandom_range(0, 3) != 0);
        bus.RdD       = AW'($urandom_range(0, 7));
        bus.KillE     = ($urandom_range(0, 5) == 0);
        bus.KillRd    = AW'($urandom_range(0, 7));
        bus.RegWriteW = ($urandom_range(0, 1) == 1);
        bus.RdW       = AW'($urandom_range(0, 7));
        bus.ResultW   = $urandom;
        ok = legal();
      end
      if (!ok) begin
        idle();
        bus.A1 = AW'($urandom_range(0, 7));
        bus.A2 = AW'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 149) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
